// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface if_stage_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_instr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// A fetch that returns while the pipe is stalled is parked in the skid buffer
// instead of being re-issued. Optional stall counter under `IF_PERF_CNT_EN.
module if_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               PC_write_i,
  input  logic               IF_ID_write_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  if_stage_if.master         imem,
  output logic [ADDR_W-1:0]  IF_ID_pc_o,
  output logic [INSTR_W-1:0] IF_ID_instr_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        stall_cnt_o,
`endif
  output logic               IF_ID_valid_o
);

  typedef enum logic {ST_REQ, ST_BUF} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  ifid_t              ifid_q, ifid_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic stall;
  logic redirect;

  assign stall    = !PC_write_i || !IF_ID_write_i;
  // A stalled ID instruction has not made its final branch decision yet.
  assign redirect = branch_i && IF_ID_write_i;

  // Next-state logic: fetch/skid rows first, redirect overrides them.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    case (state_q)
      ST_REQ: begin
        if (imem.imem_ready) begin
          if (!stall) begin
            ifid_d.pc    = pc_q;
            ifid_d.instr = imem.imem_instr;
            ifid_d.valid = 1'b1;
            pc_d         = pc_q + ADDR_W'(4);
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.imem_instr;
            state_d      = ST_BUF;
          end
        end else if (!stall) begin
          // Bubble while memory is busy; address held stable.
          ifid_d.pc    = pc_q;
          ifid_d.instr = '0;
          ifid_d.valid = 1'b0;
        end
      end
      ST_BUF: begin
        if (!stall) begin
          ifid_d.pc    = skid_pc_q;
          ifid_d.instr = skid_instr_q;
          ifid_d.valid = 1'b1;
          pc_d         = pc_q + ADDR_W'(4);
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect) begin
      pc_d    = branch_target_i;
      ifid_d  = '0;
      state_d = ST_REQ;
    end
  end

  // State, PC, IF/ID and skid registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      ifid_q       <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Request is gated by reset so memory sees no read while the stage is held in reset.
  assign imem.imem_req  = rst_i && (state_q == ST_REQ);
  assign imem.imem_addr = pc_q;
  assign IF_ID_pc_o     = ifid_q.pc;
  assign IF_ID_instr_o  = ifid_q.instr;
  assign IF_ID_valid_o  = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        cnt_evt;

  assign cnt_evt = stall || ((state_q == ST_REQ) && !imem.imem_ready);

  // Saturating count of cycles lost to hazards or memory wait.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (cnt_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of per-cycle stimulus with expected IF/ID and fetch
// outputs, pushed to a scoreboard queue when driven and popped after each edge.
module tb_if_stage;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pcw, ifw, br, rdy;
  logic [AW-1:0] tgt;
  logic [AW-1:0] ifid_pc;
  logic [IW-1:0] ifid_instr;
  logic          ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int req8   = 0;

  if_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  function automatic logic [IW-1:0] mem_rd(input logic [AW-1:0] a);
    return {a[31:16] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign bus.imem_ready = rdy;
  assign bus.imem_instr = mem_rd(bus.imem_addr);

  if_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .PC_write_i      (pcw),
    .IF_ID_write_i   (ifw),
    .branch_i        (br),
    .branch_target_i (tgt),
    .imem            (bus),
    .IF_ID_pc_o      (ifid_pc),
    .IF_ID_instr_o   (ifid_instr),
`ifdef IF_PERF_CNT_EN
    .stall_cnt_o     (stall_cnt),
`endif
    .IF_ID_valid_o   (ifid_valid)
  );

  always #5 clk = ~clk;

  // Count read requests for address 8 to prove the skid path never re-issues it.
  always @(negedge clk) if (rst && bus.imem_req && bus.imem_addr == 32'h8) req8++;

  typedef struct {
    logic          pcw, ifw, br, rdy;
    logic [AW-1:0] tgt;
    logic [AW-1:0] e_pc;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    logic          e_req;
  } vec_t;

  typedef struct {
    int            row;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          valid;
    logic [AW-1:0] addr;
    logic          req;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic p, input logic f, input logic b, input logic [AW-1:0] t,
                     input logic r, input logic [AW-1:0] epc, input logic ev,
                     input logic [AW-1:0] ea, input logic erq);
    vec_t v;
    v.pcw = p; v.ifw = f; v.br = b; v.tgt = t; v.rdy = r;
    v.e_pc = epc; v.e_valid = ev; v.e_addr = ea; v.e_req = erq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; pcw = 1'b1; ifw = 1'b1; br = 1'b0; tgt = '0; rdy = 1'b1;

    //   pcw  ifw  br   tgt            rdy   e_pc           v     e_addr         req
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h0,         1'b1, 32'h4,         1'b1); // 0 sequential
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h4,         1'b1, 32'h8,         1'b1); // 1
    add(1'b0,1'b0,1'b0,32'h0,         1'b1, 32'h4,         1'b1, 32'h8,         1'b0); // 2 stall -> BUF
    add(1'b0,1'b0,1'b0,32'h0,         1'b1, 32'h4,         1'b1, 32'h8,         1'b0); // 3 hold
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h8,         1'b1, 32'hC,         1'b1); // 4 drain skid
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'hC,         1'b1, 32'h10,        1'b1); // 5
    add(1'b1,1'b1,1'b0,32'h0,         1'b0, 32'h10,        1'b0, 32'h10,        1'b1); // 6 mem wait bubble
    add(1'b1,1'b1,1'b0,32'h0,         1'b0, 32'h10,        1'b0, 32'h10,        1'b1); // 7
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h10,        1'b1, 32'h14,        1'b1); // 8
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h14,        1'b1, 32'h18,        1'b1); // 9
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h18,        1'b1, 32'h1C,        1'b1); // 10
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h1C,        1'b1, 32'h20,        1'b1); // 11
    add(1'b1,1'b1,1'b1,32'h100,       1'b1, 32'h0,         1'b0, 32'h100,       1'b1); // 12 redirect
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h100,       1'b1, 32'h104,       1'b1); // 13
    add(1'b1,1'b0,1'b1,32'h200,       1'b1, 32'h100,       1'b1, 32'h104,       1'b0); // 14 branch ignored
    add(1'b1,1'b1,1'b1,32'h200,       1'b1, 32'h0,         1'b0, 32'h200,       1'b1); // 15 taken, skid dropped
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h200,       1'b1, 32'h204,       1'b1); // 16
    add(1'b0,1'b1,1'b0,32'h0,         1'b0, 32'h200,       1'b1, 32'h204,       1'b1); // 17 stall + not ready
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h204,       1'b1, 32'h208,       1'b1); // 18
    add(1'b1,1'b1,1'b1,32'hFFFF_FFFC, 1'b1, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1); // 19
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,         1'b1); // 20 PC wrap
    add(1'b1,1'b1,1'b1,32'h42,        1'b1, 32'h0,         1'b0, 32'h42,        1'b1); // 21 unaligned target
    add(1'b1,1'b1,1'b0,32'h0,         1'b1, 32'h42,        1'b1, 32'h46,        1'b1); // 22
    add(1'b1,1'b1,1'b1,32'h40,        1'b1, 32'h0,         1'b0, 32'h40,        1'b1); // 23 park at 0x40

    #3;
    chk("reset_req",   -1, 32'(bus.imem_req),  32'h0);
    chk("reset_addr",  -1, bus.imem_addr,      32'h0);
    chk("reset_valid", -1, 32'(ifid_valid),    32'h0);
    chk("reset_pc",    -1, ifid_pc,            32'h0);
    chk("reset_instr", -1, ifid_instr,         32'h0);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      pcw = vecs[i].pcw; ifw = vecs[i].ifw; br = vecs[i].br;
      tgt = vecs[i].tgt; rdy = vecs[i].rdy;
      e.row   = i;
      e.pc    = vecs[i].e_pc;
      e.valid = vecs[i].e_valid;
      e.instr = vecs[i].e_valid ? mem_rd(vecs[i].e_pc) : '0;
      e.addr  = vecs[i].e_addr;
      e.req   = vecs[i].e_req;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("ifid_pc",    e.row, ifid_pc,               e.pc);
      chk("ifid_instr", e.row, ifid_instr,            e.instr);
      chk("ifid_valid", e.row, 32'(ifid_valid),       32'(e.valid));
      chk("imem_addr",  e.row, bus.imem_addr,         e.addr);
      chk("imem_req",   e.row, 32'(bus.imem_req),     32'(e.req));
      @(negedge clk);
    end

    br = 1'b0;
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", 99, stall_cnt, 32'd6);
`endif
    chk("addr8_req_once", 99, 32'(req8), 32'd1);

    // Asynchronous reset between edges with PC parked at 0x40.
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_req",   100, 32'(bus.imem_req), 32'h0);
    chk("midrst_addr",  100, bus.imem_addr,     32'h0);
    chk("midrst_valid", 100, 32'(ifid_valid),   32'h0);
    chk("midrst_pc",    100, ifid_pc,           32'h0);
    chk("midrst_instr", 100, ifid_instr,        32'h0);
`ifdef IF_PERF_CNT_EN
    chk("midrst_cnt",   100, stall_cnt,         32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
